// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: word-wide valid/ready memory bus between the access unit (master)
// and the unified instruction/data memory (slave).
interface mem_access_unit_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          bus_valid;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_ready;
    logic [DW-1:0] bus_rdata;

    modport master (output bus_valid, bus_we, bus_addr, bus_wdata, input bus_ready, bus_rdata);
    modport slave  (input bus_valid, bus_we, bus_addr, bus_wdata, output bus_ready, bus_rdata);
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: multicycle fetch/load/store stage feeding IR/OldPC and the data register.
// Optional MEM_TIMEOUT_EN aborts an access after TIMEOUT_CYCLES cycles without bus_ready.
module mem_access_unit #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req,
    input  logic          we,
    input  logic          ir_write,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] pc,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] old_pc,
    output logic [DW-1:0] rdata_q,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          ovf_err,
    mem_access_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state, state_n;
    logic          fail_n;
    logic          hs;
    logic          timeout;
    logic          we_q;
    logic          ir_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [AW-1:0] pc_q;

    assign hs             = state == ACCESS && bus.bus_ready;
    assign busy           = state != IDLE;
    assign done           = state == RESP;
    assign bus.bus_valid  = state == ACCESS;
    assign bus.bus_we     = we_q;
    assign bus.bus_addr   = addr_q;
    assign bus.bus_wdata  = wdata_q;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;

    // A handshake on the last waiting cycle wins because timeout requires ~bus_ready.
    assign timeout = state == ACCESS && !bus.bus_ready && cnt == CW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (state != ACCESS)
            cnt <= '0;
        else if (!bus.bus_ready)
            cnt <= cnt + 1'b1;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        fail_n  = 1'b0;
        if (state == IDLE && req) begin
            state_n = |addr[1:0] ? RESP : ACCESS;
            fail_n  = |addr[1:0];
        end else if (state == ACCESS && (hs || timeout)) begin
            state_n = RESP;
            fail_n  = timeout;
        end else if (state == RESP) begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q    <= 1'b0;
            ir_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
            instr   <= '0;
            old_pc  <= '0;
            rdata_q <= '0;
            err     <= 1'b0;
            ovf_err <= 1'b0;
        end else begin
            err <= fail_n;
            if (req && state != IDLE)
                ovf_err <= 1'b1;
            if (req && state == IDLE) begin
                we_q    <= we;
                ir_q    <= ir_write;
                addr_q  <= addr;
                wdata_q <= wdata;
                pc_q    <= pc;
            end
            if (hs && !we_q && ir_q) begin
                instr  <= bus.bus_rdata;
                old_pc <= pc_q;
            end
            if (hs && !we_q && !ir_q)
                rdata_q <= bus.bus_rdata;
        end
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multicycle memory-access stage between the control FSM and the unified instruction/data memory bus. It takes one-cycle access requests (fetch, load, store) plus the FSM's IRWrite intent. It runs a valid/ready transaction on the memory bus and captures returned words into the instruction register (with OldPC) or the data register. It reports completion, busy and error status back to control so the FSM can hold its state until the access finishes.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width (word size; accesses are word-only)
- `TIMEOUT_CYCLES`, 16, bus wait limit; used only with `MEM_TIMEOUT_EN`
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `req`  in  1  start access, single-cycle pulse from control
- `we`  in  1  1 = store, 0 = read; sampled with `req`
- `ir_write`  in  1  read destination: 1 = IR, 0 = data register; sampled with `req`
- `addr`  in  AW  byte address; sampled with `req`
- `wdata`  in  DW  store data; sampled with `req`
- `pc`  in  AW  current PC; sampled with `req`
- `instr`  out  DW  instruction register
- `old_pc`  out  AW  PC of the instruction held in `instr`
- `rdata_q`  out  DW  data register (last load result)
- `busy`  out  1  access in progress
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  valid only with `done`: access failed
- `ovf_err`  out  1  sticky: `req` seen while busy
- `bus_valid`  out  1  bus request
- `bus_we`  out  1  bus write enable
- `bus_addr`  out  AW  bus address
- `bus_wdata`  out  DW  bus write data
- `bus_ready`  in  1  bus accepts/completes transfer
- `bus_rdata`  in  DW  read data, valid when `bus_valid & bus_ready & ~bus_we`

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: on `req`, latch `we`, `ir_write`, `addr`, `wdata` and `pc`.
  - If `addr[1:0]!=0` (misaligned): go to RESP with error flagged; no bus transaction.
  - Otherwise go to ACCESS.
- ACCESS: drive `bus_valid=1`; `bus_we`, `bus_addr` and `bus_wdata` come from the latched values and stay stable until handshake.
  - On `bus_valid & bus_ready` → RESP.
  - On a read to IR: `instr<=bus_rdata` and `old_pc<=`latched pc.
  - On a read to DR: `rdata_q<=bus_rdata`.
  - A write updates no register.
- RESP: `done=1`; `err=1` if the access was misaligned or timed out. Next state is IDLE.
- `busy = (state != IDLE)`.
- `req` while busy is ignored: the transaction is not disturbed and `ovf_err` is set. `ovf_err` is cleared only by reset.
- `req` in the same cycle that RESP is active is also ignored, because RESP counts as busy.
- A failed access (misaligned or timeout) leaves `instr`, `old_pc` and `rdata_q` unchanged.
- Reset (any time, including mid-ACCESS) is asynchronous and sets:
  - state IDLE
  - `bus_valid=0`
  - `instr`, `old_pc`, `rdata_q` = 0
  - `busy`, `done`, `err`, `ovf_err` = 0
  - `bus_we=0`, `bus_addr=0`, `bus_wdata=0`
  
  An in-flight transaction is abandoned without a response.

## Timing
- `req` sampled at edge E0.
- `bus_valid` is high from cycle E0+1.
- Handshake in cycle Ek (k≥1) → at edge Ek+1, `done` rises and `instr`/`rdata_q` show the new value in the same cycle.
- Minimum latency, `req` to `done`: 2 cycles (`bus_ready` already high).
- Misaligned access: `done` and `err` in cycle E0+1; `bus_valid` never asserts.
- `done` and `err` are registered and last exactly 1 cycle.
- The earliest next accepted `req` is in the cycle after `done`.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A counter starts at 0 on entry to ACCESS and increments each cycle without `bus_ready`.
  - If `TIMEOUT_CYCLES` cycles elapse without handshake, the unit drops `bus_valid` and goes to RESP with `err=1`.
  - A handshake on the final waiting cycle wins over the timeout.
- `MEM_TIMEOUT_EN` undefined: no counter; ACCESS waits indefinitely for `bus_ready`, and `err` arises only from misalignment.

## Test plan
- Fetch: `req=1`, `ir_write=1`, `addr=0x100`, `pc=0x100`, `bus_ready` always 1, `bus_rdata=0x00500093`. Required: `done` 2 cycles after `req`, `instr=0x00500093`, `old_pc=0x100`, `err=0`.
- Store with wait states: `we=1`, `addr=0x204`, `wdata=0xDEADBEEF`, `bus_ready` low for 3 cycles. Required:
  - `bus_valid`, `bus_addr` and `bus_wdata` held stable for 4 cycles.
  - `done` at cycle 5.
  - `rdata_q` and `instr` unchanged.
- Misaligned load at `addr=0x102`. Required: no `bus_valid`, `done=err=1` in the next cycle, `rdata_q` unchanged.
- Overlapping request: second `req` issued 1 cycle after the first. Required: first access completes normally, no second transaction, `ovf_err=1` until reset.
- Reset mid-ACCESS: drop `reset_n` while `bus_valid=1`. Required: `bus_valid=0` immediately (asynchronously), all outputs 0, and after release a new `req` works.
- With `MEM_TIMEOUT_EN` and `TIMEOUT_CYCLES=4`: `bus_ready` stuck at 0. Required: `bus_valid` drops after 4 cycles, then `done=err=1` and registers unchanged. Without the macro, `busy` stays 1 indefinitely.
